// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. A start pulse accepted in IDLE or DONE latches the
// two operands. They are then added LSB-first, one bit per clock, through one
// full-adder cell and a carry flip-flop. After WIDTH processing cycles the
// registered sum and carry-out are presented together with a one-cycle done
// strobe.
//
// Ports
//   clk        rising-edge clock, sole clock domain
//   rst        synchronous active-high reset, has priority over start
//   start      operation request, ignored while busy
//   a, b       operands, captured only on the accepted start edge
//   sum        registered (a + b) mod 2^WIDTH, changes only when done rises
//   carry_out  registered bit WIDTH of the true sum
//   busy       high while operand bits are being processed
//   done       one-cycle strobe, sum/carry_out valid
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  // The counter must hold 0..WIDTH-1. It keeps at least one bit so that
  // WIDTH=1 still has a legal declaration.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_busy;
  logic             r_done;

  logic             w_busy_next;
  logic             w_done_next;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_last;
  logic             w_s;
  logic             w_c_next;
  logic [WIDTH-1:0] w_sum_next;

  // Single full-adder cell working on the current LSBs.
  assign w_s      = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_c_next = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Partial-sum register. The new bit enters at the MSB, so after WIDTH shifts
  // the LSB-first result lines up correctly. Only the WIDTH-1 previously
  // computed bits need storage, because the final bit comes straight from the
  // adder cell on the finishing edge.
  generate
    if (WIDTH > 1) begin : g_ps
      logic [WIDTH-2:0] r_ps;

      assign w_sum_next = {w_s, r_ps};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ps <= '0;
        end else if (w_load) begin
          r_ps <= '0;
        end else if (w_step) begin
          r_ps <= w_sum_next[WIDTH-1:1];
        end
      end
    end else begin : g_no_ps
      assign w_sum_next = w_s;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, plus the next values of the registered strobes.
  always_comb begin
    w_state_next = r_state;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_busy_next  = 1'b1;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
          w_done_next  = 1'b1;
          w_finish     = 1'b1;
        end else begin
          w_busy_next = 1'b1;
        end
      end
      DONE: begin
        // Accepting start here reloads the operands with no idle gap.
        if (start) begin
          w_state_next = RUN;
          w_busy_next  = 1'b1;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa        <= '0;
      r_sb        <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      if (w_load) begin
        r_sa  <= a;
        r_sb  <= b;
        r_c   <= 1'b0;
        r_cnt <= '0;
      end else if (w_step) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_c   <= w_c_next;
        r_cnt <= r_cnt + CW'(1);
      end
      // The visible result changes only on the finishing edge.
      if (w_finish) begin
        r_sum       <= w_sum_next;
        r_carry_out <= w_c_next;
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
